// File: rtl/vga_timing_gen_prog.sv
// rtl/vga_timing_gen_prog.sv - runtime-programmable VGA/DVI timing generator
//
// Produces sync, data-enable, line/frame pre-trigger strobes and signed pixel
// coordinates from a timing set loaded through a shadowed config port. The
// shadow is applied atomically at the last pixel of a frame.
//
// Ports:
//   i_clk_pixel          pixel clock
//   i_rst_n              asynchronous active-low reset
//   i_en                 pixel clock-enable; everything except the config
//                        capture holds when low
//   i_cfg_valid          one-cycle strobe capturing all i_cfg_* fields
//   i_cfg_h_*/i_cfg_v_*  active, front porch, pulse, back porch per axis
//   i_cfg_hpol/vpol      sync active levels (1 = active-high)
//   i_cfg_scale          coordinate right-shift for the scaled outputs
//   o_cfg_pending        captured config waits for the frame boundary
//   o_hsync/o_vsync      sync outputs
//   o_data_en            active video
//   o_frame/o_line       one-cycle pre-triggers ahead of the active origin
//   o_x_pos/o_y_pos      signed coordinate
//   o_x_scaled/o_y_scaled coordinate arithmetic-shifted by the active scale
module vga_timing_gen_prog #(
  parameter int p_count_width    = 16,
  parameter int p_cfg_width      = 12,
  parameter int p_def_h_active   = 640,
  parameter int p_def_h_fp       = 16,
  parameter int p_def_h_pulse    = 96,
  parameter int p_def_h_bp       = 48,
  parameter int p_def_v_active   = 480,
  parameter int p_def_v_fp       = 10,
  parameter int p_def_v_pulse    = 2,
  parameter int p_def_v_bp       = 33,
  parameter int p_def_hpol       = 0,
  parameter int p_def_vpol       = 0,
  parameter int p_control_margin = 10,
  parameter int p_out_delay      = 0
) (
  input  logic                            i_clk_pixel,
  input  logic                            i_rst_n,
  input  logic                            i_en,
  input  logic                            i_cfg_valid,
  input  logic [p_cfg_width-1:0]          i_cfg_h_active,
  input  logic [p_cfg_width-1:0]          i_cfg_h_fp,
  input  logic [p_cfg_width-1:0]          i_cfg_h_pulse,
  input  logic [p_cfg_width-1:0]          i_cfg_h_bp,
  input  logic [p_cfg_width-1:0]          i_cfg_v_active,
  input  logic [p_cfg_width-1:0]          i_cfg_v_fp,
  input  logic [p_cfg_width-1:0]          i_cfg_v_pulse,
  input  logic [p_cfg_width-1:0]          i_cfg_v_bp,
  input  logic                            i_cfg_hpol,
  input  logic                            i_cfg_vpol,
  input  logic [1:0]                      i_cfg_scale,
  output logic                            o_cfg_pending,
  output logic                            o_hsync,
  output logic                            o_vsync,
  output logic                            o_data_en,
  output logic                            o_frame,
  output logic                            o_line,
  output logic signed [p_count_width-1:0] o_x_pos,
  output logic signed [p_count_width-1:0] o_y_pos,
  output logic signed [p_count_width-1:0] o_x_scaled,
  output logic signed [p_count_width-1:0] o_y_scaled
);

  localparam int W = p_count_width;
  localparam int CW = p_cfg_width;
  localparam int c_out_w = 5 + 4 * W;

  typedef struct packed {
    logic [CW-1:0] h_active;
    logic [CW-1:0] h_fp;
    logic [CW-1:0] h_pulse;
    logic [CW-1:0] h_bp;
    logic [CW-1:0] v_active;
    logic [CW-1:0] v_fp;
    logic [CW-1:0] v_pulse;
    logic [CW-1:0] v_bp;
    logic          hpol;
    logic          vpol;
    logic [1:0]    scale;
  } cfg_t;

  localparam cfg_t c_def_cfg = '{
    h_active: CW'(p_def_h_active),
    h_fp:     CW'(p_def_h_fp),
    h_pulse:  CW'(p_def_h_pulse),
    h_bp:     CW'(p_def_h_bp),
    v_active: CW'(p_def_v_active),
    v_fp:     CW'(p_def_v_fp),
    v_pulse:  CW'(p_def_v_pulse),
    v_bp:     CW'(p_def_v_bp),
    hpol:     (p_def_hpol != 0),
    vpol:     (p_def_vpol != 0),
    scale:    2'd0
  };

  localparam logic signed [W-1:0] c_one        = W'(1);
  localparam logic signed [W-1:0] c_neg_margin = W'(-p_control_margin);
  localparam logic signed [W-1:0] c_def_x_org  = W'(-(p_def_h_fp + p_def_h_pulse + p_def_h_bp));
  localparam logic signed [W-1:0] c_def_y_org  = W'(-(p_def_v_fp + p_def_v_pulse + p_def_v_bp));
  localparam logic                c_rst_hsync  = (p_def_hpol == 0);
  localparam logic                c_rst_vsync  = (p_def_vpol == 0);

  // Reset image of the output bundle; the delay line starts out full of it.
  localparam logic [c_out_w-1:0] c_rst_vec = {c_rst_hsync, c_rst_vsync, 3'b000,
                                              c_def_x_org, c_def_y_org,
                                              c_def_x_org, c_def_y_org};

  // Config fields are unsigned; widen them into the signed coordinate domain.
  function automatic logic signed [W-1:0] ext(input logic [CW-1:0] v);
    ext = $signed({{(W-CW){1'b0}}, v});
  endfunction

  function automatic logic signed [W-1:0] h_origin(input cfg_t c);
    h_origin = -(ext(c.h_fp) + ext(c.h_pulse) + ext(c.h_bp));
  endfunction

  function automatic logic signed [W-1:0] v_origin(input cfg_t c);
    v_origin = -(ext(c.v_fp) + ext(c.v_pulse) + ext(c.v_bp));
  endfunction

  cfg_t cfg_in;
  cfg_t cfg_q, cfg_d;
  cfg_t shadow_q, shadow_d;
  logic pending_q, pending_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d;
  logic signed [W-1:0] xs_q, xs_d, ys_q, ys_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic de_q, de_d, frame_q, frame_d, line_q, line_d;

  logic h_last, v_last, hs_act, vs_act;
  logic signed [W-1:0] hs_start, hs_stop, vs_start, vs_stop;

  logic [c_out_w-1:0] gen_vec;
  logic [c_out_w-1:0] out_vec;

  assign cfg_in = '{
    h_active: i_cfg_h_active, h_fp: i_cfg_h_fp, h_pulse: i_cfg_h_pulse, h_bp: i_cfg_h_bp,
    v_active: i_cfg_v_active, v_fp: i_cfg_v_fp, v_pulse: i_cfg_v_pulse, v_bp: i_cfg_v_bp,
    hpol: i_cfg_hpol, vpol: i_cfg_vpol, scale: i_cfg_scale
  };

  always_comb begin
    cfg_d     = cfg_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    x_d       = x_q;
    y_d       = y_q;
    xs_d      = xs_q;
    ys_d      = ys_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    de_d      = de_q;
    frame_d   = frame_q;
    line_d    = line_q;
    h_last    = 1'b0;
    v_last    = 1'b0;
    hs_act    = 1'b0;
    vs_act    = 1'b0;
    hs_start  = '0;
    hs_stop   = '0;
    vs_start  = '0;
    vs_stop   = '0;

    // Capture is independent of the pixel enable; last write wins.
    if (i_cfg_valid) begin
      shadow_d  = cfg_in;
      pending_d = 1'b1;
    end

    if (i_en) begin
      h_last = (x_q == ext(cfg_q.h_active) - c_one);
      v_last = (y_q == ext(cfg_q.v_active) - c_one);

      if (h_last && v_last) begin
        // Frame boundary: the old shadow becomes active; a strobe landing
        // in this very cycle keeps pending set for the following frame.
        cfg_d = shadow_q;
        if (!i_cfg_valid) begin
          pending_d = 1'b0;
        end
        x_d = h_origin(shadow_q);
        y_d = v_origin(shadow_q);
      end else if (h_last) begin
        x_d = h_origin(cfg_q);
        y_d = y_q + c_one;
      end else begin
        x_d = x_q + c_one;
      end

      // Decode from the next coordinate with the config it belongs to, so the
      // registered flags line up with the registered coordinate.
      hs_start = h_origin(cfg_d) + ext(cfg_d.h_fp);
      hs_stop  = hs_start + ext(cfg_d.h_pulse) - c_one;
      vs_start = v_origin(cfg_d) + ext(cfg_d.v_fp);
      vs_stop  = vs_start + ext(cfg_d.v_pulse) - c_one;
      hs_act   = (x_d >= hs_start) && (x_d <= hs_stop);
      vs_act   = (y_d >= vs_start) && (y_d <= vs_stop);

      hsync_d  = ~(hs_act ^ cfg_d.hpol);
      vsync_d  = ~(vs_act ^ cfg_d.vpol);
      de_d     = !x_d[W-1] && (x_d < ext(cfg_d.h_active)) &&
                 !y_d[W-1] && (y_d < ext(cfg_d.v_active));
      line_d   = (x_d == c_neg_margin);
      frame_d  = (x_d == c_neg_margin) && (y_d == c_neg_margin);
      xs_d     = x_d >>> cfg_d.scale;
      ys_d     = y_d >>> cfg_d.scale;
    end
  end

  always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cfg_q     <= c_def_cfg;
      shadow_q  <= c_def_cfg;
      pending_q <= 1'b0;
      x_q       <= c_def_x_org;
      y_q       <= c_def_y_org;
      xs_q      <= c_def_x_org;
      ys_q      <= c_def_y_org;
      hsync_q   <= c_rst_hsync;
      vsync_q   <= c_rst_vsync;
      de_q      <= 1'b0;
      frame_q   <= 1'b0;
      line_q    <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      x_q       <= x_d;
      y_q       <= y_d;
      xs_q      <= xs_d;
      ys_q      <= ys_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      frame_q   <= frame_d;
      line_q    <= line_d;
    end
  end

  assign gen_vec = {hsync_q, vsync_q, de_q, frame_q, line_q, x_q, y_q, xs_q, ys_q};

  generate
    if (p_out_delay == 0) begin : g_nodly
      assign out_vec = gen_vec;
    end else begin : g_dly
      logic [c_out_w-1:0] dly_q [p_out_delay];
      logic [c_out_w-1:0] dly_d [p_out_delay];

      // Shift only on enabled cycles so the delay is counted in pixels.
      always_comb begin
        dly_d = dly_q;
        if (i_en) begin
          dly_d[0] = gen_vec;
          for (int i = 1; i < p_out_delay; i++) begin
            dly_d[i] = dly_q[i-1];
          end
        end
      end

      always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < p_out_delay; i++) begin
            dly_q[i] <= c_rst_vec;
          end
        end else begin
          dly_q <= dly_d;
        end
      end

      assign out_vec = dly_q[p_out_delay-1];
    end
  endgenerate

  assign {o_hsync, o_vsync, o_data_en, o_frame, o_line,
          o_x_pos, o_y_pos, o_x_scaled, o_y_scaled} = out_vec;
  assign o_cfg_pending = pending_q;

endmodule

// File: tb/tb_vga_timing_gen_prog.sv
// tb/tb_vga_timing_gen_prog.sv - self-checking bench for vga_timing_gen_prog
module tb_vga_timing_gen_prog;

  localparam int MARGIN = 10;

  typedef struct packed {
    int ha; int hf; int hp; int hb;
    int va; int vf; int vp; int vb;
    int hpol; int vpol; int scale;
  } cfg_s;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, cfg_valid;
  logic [11:0] c_ha, c_hf, c_hp, c_hb, c_va, c_vf, c_vp, c_vb;
  logic c_hpol, c_vpol;
  logic [1:0] c_scale;

  logic f_pend, f_hs, f_vs, f_de, f_fr, f_ln;
  logic signed [15:0] f_x, f_y, f_xs, f_ys;
  logic s_pend, s_hs, s_vs, s_de, s_fr, s_ln;
  logic signed [15:0] s_x, s_y, s_xs, s_ys;
  logic d_pend, d_hs, d_vs, d_de, d_fr, d_ln;
  logic signed [15:0] d_x, d_y, d_xs, d_ys;
  logic [68:0] f_vec, s_vec, d_vec;

  assign f_vec = {f_hs, f_vs, f_de, f_fr, f_ln, f_x, f_y, f_xs, f_ys};
  assign s_vec = {s_hs, s_vs, s_de, s_fr, s_ln, s_x, s_y, s_xs, s_ys};
  assign d_vec = {d_hs, d_vs, d_de, d_fr, d_ln, d_x, d_y, d_xs, d_ys};

  vga_timing_gen_prog dut_full (
    .i_clk_pixel(clk), .i_rst_n(rst_n), .i_en(en), .i_cfg_valid(cfg_valid),
    .i_cfg_h_active(c_ha), .i_cfg_h_fp(c_hf), .i_cfg_h_pulse(c_hp), .i_cfg_h_bp(c_hb),
    .i_cfg_v_active(c_va), .i_cfg_v_fp(c_vf), .i_cfg_v_pulse(c_vp), .i_cfg_v_bp(c_vb),
    .i_cfg_hpol(c_hpol), .i_cfg_vpol(c_vpol), .i_cfg_scale(c_scale),
    .o_cfg_pending(f_pend), .o_hsync(f_hs), .o_vsync(f_vs), .o_data_en(f_de),
    .o_frame(f_fr), .o_line(f_ln), .o_x_pos(f_x), .o_y_pos(f_y),
    .o_x_scaled(f_xs), .o_y_scaled(f_ys)
  );

  vga_timing_gen_prog #(
    .p_def_h_active(16), .p_def_h_fp(4), .p_def_h_pulse(3), .p_def_h_bp(5),
    .p_def_v_active(5), .p_def_v_fp(3), .p_def_v_pulse(2), .p_def_v_bp(6),
    .p_def_hpol(0), .p_def_vpol(1), .p_out_delay(0)
  ) dut_s0 (
    .i_clk_pixel(clk), .i_rst_n(rst_n), .i_en(en), .i_cfg_valid(cfg_valid),
    .i_cfg_h_active(c_ha), .i_cfg_h_fp(c_hf), .i_cfg_h_pulse(c_hp), .i_cfg_h_bp(c_hb),
    .i_cfg_v_active(c_va), .i_cfg_v_fp(c_vf), .i_cfg_v_pulse(c_vp), .i_cfg_v_bp(c_vb),
    .i_cfg_hpol(c_hpol), .i_cfg_vpol(c_vpol), .i_cfg_scale(c_scale),
    .o_cfg_pending(s_pend), .o_hsync(s_hs), .o_vsync(s_vs), .o_data_en(s_de),
    .o_frame(s_fr), .o_line(s_ln), .o_x_pos(s_x), .o_y_pos(s_y),
    .o_x_scaled(s_xs), .o_y_scaled(s_ys)
  );

  vga_timing_gen_prog #(
    .p_def_h_active(16), .p_def_h_fp(4), .p_def_h_pulse(3), .p_def_h_bp(5),
    .p_def_v_active(5), .p_def_v_fp(3), .p_def_v_pulse(2), .p_def_v_bp(6),
    .p_def_hpol(0), .p_def_vpol(1), .p_out_delay(3)
  ) dut_s3 (
    .i_clk_pixel(clk), .i_rst_n(rst_n), .i_en(en), .i_cfg_valid(cfg_valid),
    .i_cfg_h_active(c_ha), .i_cfg_h_fp(c_hf), .i_cfg_h_pulse(c_hp), .i_cfg_h_bp(c_hb),
    .i_cfg_v_active(c_va), .i_cfg_v_fp(c_vf), .i_cfg_v_pulse(c_vp), .i_cfg_v_bp(c_vb),
    .i_cfg_hpol(c_hpol), .i_cfg_vpol(c_vpol), .i_cfg_scale(c_scale),
    .o_cfg_pending(d_pend), .o_hsync(d_hs), .o_vsync(d_vs), .o_data_en(d_de),
    .o_frame(d_fr), .o_line(d_ln), .o_x_pos(d_x), .o_y_pos(d_y),
    .o_x_scaled(d_xs), .o_y_scaled(d_ys)
  );

  int checks = 0;
  int errors = 0;

  cfg_s def_f, def_s, act_f, shd_f, act_s, shd_s, drv;
  int n_f, n_s;
  bit pend_f, pend_s;
  logic [68:0] hist[$];

  function automatic int frame_len(cfg_s c);
    return (c.ha + c.hf + c.hp + c.hb) * (c.va + c.vf + c.vp + c.vb);
  endfunction

  // Position n (enabled cycles since frame start) mapped to the expected outputs.
  function automatic logic [68:0] expect_out(cfg_s c, int n);
    int ht, col, row, x, y, xs, ys;
    bit hact, vact, hs, vs, de, ln, fr;
    ht   = c.ha + c.hf + c.hp + c.hb;
    col  = n % ht;
    row  = n / ht;
    x    = col - (c.hf + c.hp + c.hb);
    y    = row - (c.vf + c.vp + c.vb);
    hact = (col >= c.hf) && (col < c.hf + c.hp);
    vact = (row >= c.vf) && (row < c.vf + c.vp);
    hs   = (c.hpol != 0) ? hact : !hact;
    vs   = (c.vpol != 0) ? vact : !vact;
    de   = (x >= 0) && (y >= 0);
    ln   = (x == -MARGIN);
    fr   = ln && (y == -MARGIN);
    xs   = x >>> c.scale;
    ys   = y >>> c.scale;
    return {hs, vs, de, fr, ln, x[15:0], y[15:0], xs[15:0], ys[15:0]};
  endfunction

  function automatic cfg_s rand_cfg();
    cfg_s c;
    int t;
    c.ha = $urandom_range(1, 24);
    c.hf = $urandom_range(0, 5);
    c.hp = $urandom_range(1, 5);
    t = 10 - c.hf - c.hp;
    c.hb = ((t > 0) ? t : 0) + int'($urandom_range(0, 4));
    c.va = $urandom_range(1, 6);
    c.vf = $urandom_range(0, 4);
    c.vp = $urandom_range(1, 3);
    t = 10 - c.vf - c.vp;
    c.vb = ((t > 0) ? t : 0) + int'($urandom_range(0, 3));
    c.hpol  = $urandom_range(0, 1);
    c.vpol  = $urandom_range(0, 1);
    c.scale = $urandom_range(0, 3);
    return c;
  endfunction

  task automatic reset_models();
    act_f = def_f; shd_f = def_f; n_f = 0; pend_f = 1'b0;
    act_s = def_s; shd_s = def_s; n_s = 0; pend_s = 1'b0;
    hist.delete();
    repeat (4) hist.push_back(expect_out(def_s, 0));
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      reset_models();
    end else begin
      if (en) begin
        if (n_f == frame_len(act_f) - 1) begin
          act_f = shd_f; n_f = 0; pend_f = 1'b0;
        end else begin
          n_f++;
        end
        if (n_s == frame_len(act_s) - 1) begin
          act_s = shd_s; n_s = 0; pend_s = 1'b0;
        end else begin
          n_s++;
        end
        hist.push_back(expect_out(act_s, n_s));
        void'(hist.pop_front());
      end
      if (cfg_valid) begin
        shd_f = drv; pend_f = 1'b1;
        shd_s = drv; pend_s = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("full_outputs", f_vec, expect_out(act_f, n_f));
    chk("small_outputs", s_vec, expect_out(act_s, n_s));
    chk("small_dly3_outputs", d_vec, hist[0]);
    chk_int("full_pending", f_pend, pend_f);
    chk_int("small_pending", s_pend, pend_s);
    chk_int("dly3_pending", d_pend, pend_s);
  endtask

  task automatic set_inputs(input bit en_v, input bit strobe);
    en        = en_v;
    cfg_valid = strobe;
    if (strobe) begin
      drv     = rand_cfg();
      c_ha    = 12'(drv.ha); c_hf = 12'(drv.hf); c_hp = 12'(drv.hp); c_hb = 12'(drv.hb);
      c_va    = 12'(drv.va); c_vf = 12'(drv.vf); c_vp = 12'(drv.vp); c_vb = 12'(drv.vb);
      c_hpol  = drv.hpol[0];
      c_vpol  = drv.vpol[0];
      c_scale = drv.scale[1:0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  function automatic bit pick_strobe(input bit en_v);
    bit at_wrap;
    at_wrap = en_v && (n_s == frame_len(act_s) - 1) && ($urandom_range(0, 2) == 0);
    return at_wrap || ($urandom_range(0, 399) == 0);
  endfunction

  int first_de, first_vs, first_fr, hs_low, line_cnt;
  int rise1, rise2;
  bit prev_ln, ev;

  initial begin
    def_f = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 0};
    def_s = '{16, 4, 3, 5, 5, 3, 2, 6, 0, 1, 0};
    drv = def_s;
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    c_ha = '0; c_hf = '0; c_hp = '0; c_hb = '0;
    c_va = '0; c_vf = '0; c_vp = '0; c_vb = '0;
    c_hpol = 1'b0; c_vpol = 1'b0; c_scale = 2'd0;
    reset_models();

    // Reset state.
    step();
    step();
    chk_int("rst_x", f_x, -160);
    chk_int("rst_y", f_y, -45);
    chk_int("rst_hsync", f_hs, 1);
    chk_int("rst_vsync", f_vs, 1);
    chk_int("rst_de", f_de, 0);
    chk_int("rst_small_vsync", s_vs, 0);

    // Defaults, continuous enable, random config traffic on the small instances.
    rst_n = 1'b1;
    first_de = -1; first_vs = -1; first_fr = -1; hs_low = 0; line_cnt = 0;
    for (int k = 1; k <= 36200 && errors < 20; k++) begin
      set_inputs(1'b1, pick_strobe(1'b1));
      step();
      if (k < 800 && f_hs == 1'b0) hs_low++;
      if (k <= 36160 && f_ln) line_cnt++;
      if (first_de < 0 && f_de) first_de = k;
      if (first_vs < 0 && !f_vs) first_vs = k;
      if (first_fr < 0 && f_fr) first_fr = k;
    end
    chk_int("hsync_low_first_line", hs_low, 96);
    chk_int("first_vsync_cycle", first_vs, 8000);
    chk_int("first_frame_cycle", first_fr, 28150);
    chk_int("first_de_cycle", first_de, 36160);
    chk_int("line_pulses", line_cnt, 46);

    // Enable toggling every cycle: line period doubles in clocks.
    rise1 = -1; rise2 = -1; prev_ln = f_ln;
    for (int i = 0; i < 5000 && errors < 20; i++) begin
      ev = (i % 2 == 0);
      set_inputs(ev, pick_strobe(ev));
      step();
      if (f_ln && !prev_ln) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      prev_ln = f_ln;
    end
    chk_int("line_period_toggle", rise2 - rise1, 1600);

    // Random enable pattern.
    for (int i = 0; i < 12000 && errors < 20; i++) begin
      ev = ($urandom_range(0, 3) != 0);
      set_inputs(ev, pick_strobe(ev));
      step();
    end

    // Asynchronous reset mid-line, checked before the next clock edge.
    set_inputs(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    reset_models();
    check_all();
    chk_int("async_rst_x", f_x, -160);
    chk_int("async_rst_small_x", s_x, -12);
    chk_int("async_rst_pending", s_pend, 0);
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 3000 && errors < 20; i++) begin
      ev = ($urandom_range(0, 4) != 0);
      set_inputs(ev, pick_strobe(ev));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen_prog.md
Name: vga_timing_gen_prog

Overview:
Runtime-programmable successor to the fixed-mode VGA/DVI timing generator. It produces hsync, vsync, data-enable, frame/line pre-trigger strobes and signed pixel coordinates. The timing set is loaded through a config port and applied atomically at frame boundaries. It adds a pixel clock-enable, per-mode sync polarity, scaled coordinates for upsampling low-resolution thermal frames, and a parametrised output delay line that aligns the outputs with downstream pixel-pipeline latency.

Parameters:
p_count_width, 16, signed width of coordinate counters and outputs
p_cfg_width, 12, width of each timing config field
p_def_h_active, 640, reset horizontal active pixels
p_def_h_fp / p_def_h_pulse / p_def_h_bp, 16 / 96 / 48, reset horizontal porches and pulse
p_def_v_active, 480, reset vertical active lines
p_def_v_fp / p_def_v_pulse / p_def_v_bp, 10 / 2 / 33, reset vertical porches and pulse
p_def_hpol / p_def_vpol, 0 / 0, reset sync active level (1 = active-high)
p_control_margin, 10, pre-trigger distance (pixels and lines) before the active origin
p_out_delay, 0, number of extra register stages on all outputs (0..15)

Ports:
i_clk_pixel  in  1  pixel clock
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  pixel clock-enable; counters advance only when high
i_cfg_valid  in  1  single-cycle strobe; captures all i_cfg_* fields
i_cfg_h_active, i_cfg_h_fp, i_cfg_h_pulse, i_cfg_h_bp  in  p_cfg_width each  horizontal timing
i_cfg_v_active, i_cfg_v_fp, i_cfg_v_pulse, i_cfg_v_bp  in  p_cfg_width each  vertical timing
i_cfg_hpol, i_cfg_vpol  in  1 each  sync active levels
i_cfg_scale  in  2  coordinate right-shift (0..3)
o_cfg_pending  out  1  captured config is waiting for the frame boundary
o_hsync, o_vsync  out  1  sync outputs
o_data_en  out  1  active video
o_frame  out  1  one-cycle frame pre-trigger
o_line  out  1  one-cycle line pre-trigger
o_x_pos, o_y_pos  out  p_count_width signed  current coordinate
o_x_scaled, o_y_scaled  out  p_count_width signed  coordinate arithmetic-shifted right by the active scale

Behaviour:
- Reset is asynchronous and active-low. The team's decided interface is exactly: one clock; reset is asynchronous and active-low. Clock is i_clk_pixel; reset is i_rst_n.
- Reset state:
  - Active and shadow config registers = defaults; scale = 0; o_cfg_pending = 0.
  - x = x_origin, y = y_origin.
  - hsync and vsync at their inactive levels (~pol).
  - data_en, frame and line = 0.
  - All delay-line stages hold these reset values.
- Origins: x_origin = -(h_fp+h_pulse+h_bp); y_origin = -(v_fp+v_pulse+v_bp). Active area is x in [0, h_active-1], y in [0, v_active-1]. Blanking precedes active video.
- Counting (only in cycles with i_en = 1; with i_en = 0 every register, including the delay line, holds):
  - x increments; at x = h_active-1, x wraps to x_origin and y advances.
  - y wraps from v_active-1 to y_origin.
- Registered decode, aligned with the coordinate on the same output cycle:
  - hsync active when x in [x_origin+h_fp, x_origin+h_fp+h_pulse-1].
  - vsync active when y in [y_origin+v_fp, y_origin+v_fp+v_pulse-1].
  - data_en = x and y both in the active area.
  - line = (x == -p_control_margin).
  - frame = line AND (y == -p_control_margin).
- Scaled coordinates = x >>> scale and y >>> scale, computed from the same registered coordinate.
- Config handshake:
  - i_cfg_valid (sampled when high, regardless of i_en) loads the shadow registers and sets o_cfg_pending.
  - A new strobe while pending overwrites the shadow; last write wins.
  - The shadow is applied in the enabled cycle where x = h_active-1 and y = v_active-1. The counters then load the new x_origin/y_origin, and o_cfg_pending clears.
  - A strobe in that same cycle: the previous shadow is applied, the new value is captured, and pending stays 1.
- Delay line: every output except o_cfg_pending passes through p_out_delay stages advanced by i_en. With p_out_delay = 0 the outputs come straight from the generator registers.
- Config legality (not checked in RTL): h_pulse ≥ 1, v_pulse ≥ 1, active ≥ 1, and p_control_margin ≤ total blanking on each axis. Behaviour for illegal config is undefined but must not lock up; the next valid config applies at the next wrap.
- Reset asserted mid-frame forces the reset state immediately. After deassertion, counting resumes from the origin with the default config.

Test Plan:
- Defaults, i_en = 1:
  - Line period = 800 cycles; hsync active for x = -144..-49 (96 cycles, low).
  - Frame = 525 lines; vsync low for y = -35..-34.
  - data_en high for 640 cycles per line on 480 lines.
- Pre-triggers: o_line pulses once per line at x = -10. o_frame pulses once per frame, at x = -10, y = -10.
- Config 320x240, fp/pulse/bp 8/32/40 and 3/4/6, hpol = vpol = 1, strobed mid-frame:
  - o_cfg_pending stays high until the wrap at (639, 479).
  - The next cycle shows x = -80, y = -13.
  - Next line period = 400 cycles; syncs are active-high.
- Scale = 2: o_x_scaled = 0 for x = 0..3, 159 at x = 639; o_x_scaled = -1 at x = -1.
- i_en toggling 1/0 every cycle: line period = 1600 clocks and all outputs hold on disabled cycles. With p_out_delay = 3, outputs equal the p_out_delay = 0 outputs shifted by exactly 3 enabled cycles.
- Reset pulse at y = 200: outputs go to reset values asynchronously. After release, the defaults apply and the first data_en appears after the full blanking of 45 lines × 800 plus 160 cycles.
